// File: rtl/mpadder_stream_loader_pkg.sv
// Shared types and sizing helpers for the multi-precision adder stream loader.
package mpadder_stream_loader_pkg;

   localparam int DEF_WORD_W      = 32;
   localparam int DEF_OP_W        = 128;
   localparam int DEF_WDOG_CYCLES = 15;

   typedef enum logic [2:0] {
      S_LOAD_A = 3'd0,
      S_LOAD_B = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   // Words needed to carry an (op_w+1)-bit sum: ceil((op_w+1)/word_w).
   function automatic int n_out(input int op_w, input int word_w);
      return (op_w + word_w) / word_w;
   endfunction

endpackage

// File: rtl/mpadder_stream_loader_if.sv
// Operand stream, adder hookup and result stream of the loader, bundled as one interface.
interface mpadder_stream_loader_if
   import mpadder_stream_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int OP_W   = DEF_OP_W
);
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic              add_start;
   logic [OP_W-1:0]   add_A;
   logic [OP_W-1:0]   add_B;
   logic [OP_W:0]     add_C;
   logic              add_done;
   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   modport master (
      input  in_valid, in_data, add_C, add_done, out_ready,
      output in_ready, add_start, add_A, add_B, out_valid, out_data, out_last
   );

   modport slave (
      output in_valid, in_data, add_C, add_done, out_ready,
      input  in_ready, add_start, add_A, add_B, out_valid, out_data, out_last
   );
endinterface

// File: rtl/mpadder_stream_loader_shreg.sv
// Word-wide right shift register with parallel load; new words enter at the MS end.
module mp_word_shreg #(
   parameter int WIDTH  = 128,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [WIDTH-1:0]  d_full,
   input  logic [WORD_W-1:0] d_word,
   output logic [WIDTH-1:0]  q
);

   always_ff @(posedge clk) begin
      if (rst)        q <= '0;
      else if (load)  q <= d_full;
      else if (shift) q <= {d_word, q[WIDTH-1:WORD_W]};
   end

endmodule

// File: rtl/mpadder_stream_loader.sv
// Streams operands A/B into the adder, pulses start, then streams the sum back out.
// Watchdog on the adder wait is built only when MPADDER_LOADER_WDOG_EN is defined.
//
// state    | meaning
// S_LOAD_A | accepting operand A words (idle when cnt == 0)
// S_LOAD_B | accepting operand B words
// S_START  | one-cycle add_start pulse
// S_WAIT   | waiting for add_done (optionally watchdog-limited)
// S_DRAIN  | returning the sum words, carry word last
module mpadder_stream_loader
   import mpadder_stream_loader_pkg::*;
#(
   parameter int WORD_W      = DEF_WORD_W,
   parameter int OP_W        = DEF_OP_W,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   mpadder_stream_loader_if.master bus,
   output logic                    busy,
   output logic                    err
);

   localparam int N_IN  = OP_W / WORD_W;
   localparam int N_OUT = n_out(OP_W, WORD_W);
   localparam int RES_W = N_OUT * WORD_W;
   localparam int CNT_W = $clog2(N_OUT + 1);
   localparam int WD_W  = $clog2(WDOG_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(N_IN - 1);
   localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(N_OUT - 1);
`ifdef MPADDER_LOADER_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WD_W-1:0]    wdog_q;
   logic               err_q;
   logic [OP_W-1:0]    a_q, b_q;
   logic [RES_W-1:0]   res_q;
   logic               in_rdy, start, oval, olast;
   logic               a_shift, b_shift, r_load, r_shift, wdog_to;
   logic               unused_res_hi;

   mp_word_shreg #(.WIDTH(OP_W), .WORD_W(WORD_W)) u_a (
      .clk(clk), .rst(rst), .load(1'b0), .shift(a_shift),
      .d_full('0), .d_word(bus.in_data), .q(a_q)
   );

   mp_word_shreg #(.WIDTH(OP_W), .WORD_W(WORD_W)) u_b (
      .clk(clk), .rst(rst), .load(1'b0), .shift(b_shift),
      .d_full('0), .d_word(bus.in_data), .q(b_q)
   );

   mp_word_shreg #(.WIDTH(RES_W), .WORD_W(WORD_W)) u_res (
      .clk(clk), .rst(rst), .load(r_load), .shift(r_shift),
      .d_full({{(RES_W-OP_W-1){1'b0}}, bus.add_C}), .d_word('0), .q(res_q)
   );

   // Upper result bits are only consumed through the shift path inside u_res.
   assign unused_res_hi = ^res_q[RES_W-1:WORD_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD_A;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      in_rdy  = 1'b0;
      start   = 1'b0;
      oval    = 1'b0;
      olast   = 1'b0;
      a_shift = 1'b0;
      b_shift = 1'b0;
      r_load  = 1'b0;
      r_shift = 1'b0;
      wdog_to = 1'b0;
      case (state_q)
         S_LOAD_A, S_LOAD_B: begin
            in_rdy = 1'b1;
            if (bus.in_valid) begin
               a_shift = (state_q == S_LOAD_A);
               b_shift = (state_q == S_LOAD_B);
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_IN) begin
                  cnt_d   = '0;
                  state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
               end
            end
         end
         S_START: begin
            start   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.add_done) begin
               r_load  = 1'b1;
               state_d = S_DRAIN;
            end else if (WDOG_EN && wdog_q == '0) begin
               wdog_to = 1'b1;
               state_d = S_LOAD_A;
            end
         end
         S_DRAIN: begin
            oval  = 1'b1;
            olast = (cnt_q == LAST_OUT);
            if (bus.out_ready) begin
               r_shift = 1'b1;
               cnt_d   = olast ? '0 : cnt_q + 1'b1;
               if (olast) state_d = S_LOAD_A;
            end
         end
         default: begin
            state_d = S_LOAD_A;
            cnt_d   = '0;
         end
      endcase
   end

   // Down-counter armed in S_START so the limit counts cycles spent in S_WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state_q == S_START)
            wdog_q <= WD_W'(WDOG_CYCLES - 1);
         else if (state_q == S_WAIT && wdog_q != '0)
            wdog_q <= wdog_q - 1'b1;
         if (wdog_to)
            err_q <= 1'b1;
      end
   end

   assign err           = WDOG_EN && err_q && !rst;
   assign busy          = !rst && !(state_q == S_LOAD_A && cnt_q == '0);
   assign bus.in_ready  = in_rdy && !rst;
   assign bus.add_start = start && !rst;
   assign bus.add_A     = rst ? '0 : a_q;
   assign bus.add_B     = rst ? '0 : b_q;
   assign bus.out_valid = oval && !rst;
   assign bus.out_last  = olast && !rst;
   assign bus.out_data  = rst ? '0 : res_q[WORD_W-1:0];

endmodule
